// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC walks every neuron's weights
// and bias in the external weight RAM, then rescales, saturates and optionally applies ReLU.
module nn_layer_seq #(
    parameter int unsigned N_IN   = 10,
    parameter int unsigned N_NEU  = 5,
    parameter int unsigned DW     = 10,
    parameter int unsigned WW     = 10,
    parameter int unsigned FRAC   = 4,
    parameter int unsigned ACT    = 1,
    parameter int unsigned AWID   = 7,
    parameter int unsigned W_BASE = 0
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  i_start,
    input  logic [N_IN*DW-1:0]    i_in_vec,
    output logic [AWID-1:0]       o_w_addr,
    output logic                  o_w_rd_en,
    input  logic [WW-1:0]         i_w_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_out_valid,
    output logic [N_NEU*DW-1:0]   o_out_vec
);

    localparam int unsigned AW = DW + WW + $clog2(N_IN + 1) + 1;
    localparam int unsigned PW = DW + WW;
    localparam int unsigned IW = $clog2(N_IN + 1);
    localparam int unsigned NW = (N_NEU > 1) ? $clog2(N_NEU) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_IN);
    localparam logic [NW-1:0] N_LAST   = NW'(N_NEU - 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((longint'(1) <<< (DW - 1)) - longint'(1));
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StWrite, StDone} state_t;

    state_t                 r_state, w_state_next;
    // One spare slot so the bias fetch index (N_IN) stays in range; it is never loaded.
    logic signed [DW-1:0]   r_x [N_IN+1];
    logic [IW-1:0]          r_idx;
    logic [NW-1:0]          r_n;
    logic signed [AW-1:0]   r_acc;
    logic                   r_rd_vld;
    logic [IW-1:0]          r_rd_idx;
    logic signed [DW-1:0]   r_out [N_NEU];
    logic                   r_out_valid;

    logic signed [PW-1:0]   w_x_ext, w_w_ext, w_prod;
    logic signed [AW-1:0]   w_bias, w_term, w_shift;
    logic signed [DW-1:0]   w_sat;
    logic [AWID-1:0]        w_addr;

    // Product of the input addressed by the returning fetch and its weight, or the aligned bias.
    assign w_x_ext = PW'(r_x[r_rd_idx]);
    assign w_w_ext = PW'($signed(i_w_data));
    assign w_prod  = w_x_ext * w_w_ext;
    assign w_bias  = AW'($signed(i_w_data)) <<< FRAC;
    assign w_term  = (r_rd_idx == IDX_LAST) ? w_bias : AW'(w_prod);
    assign w_shift = r_acc >>> FRAC;
    assign w_addr  = AWID'(32'(W_BASE) + 32'(r_n) * 32'(N_IN + 1) + 32'(r_idx));

    // Rescaled result: saturate to the data range, then the optional ReLU.
    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[DW-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[DW-1:0];
        end
        if (ACT == 1 && w_sat[DW-1]) begin
            w_sat = '0;
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        o_w_rd_en    = 1'b0;
        o_w_addr     = '0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                o_w_rd_en = 1'b1;
                o_w_addr  = w_addr;
                if (r_idx == IDX_LAST) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: w_state_next = StWrite;
            StWrite: w_state_next = (r_n == N_LAST) ? StDone : StRun;
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: input latch, fetch counters, accumulator and result bank.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i <= N_IN; i++) begin
                r_x[i] <= '0;
            end
            for (int n = 0; n < N_NEU; n++) begin
                r_out[n] <= '0;
            end
            r_idx       <= '0;
            r_n         <= '0;
            r_acc       <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // RAM data returns one cycle after the read, so the fetch index is delayed with it.
            r_rd_vld <= (r_state == StRun);
            r_rd_idx <= r_idx;
            if (r_rd_vld) begin
                r_acc <= r_acc + w_term;
            end
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        for (int i = 0; i < N_IN; i++) begin
                            r_x[i] <= i_in_vec[i*DW +: DW];
                        end
                        r_n         <= '0;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                StRun: begin
                    if (r_idx != IDX_LAST) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                StWrite: begin
                    r_out[r_n] <= w_sat;
                    r_acc      <= '0;
                    r_idx      <= '0;
                    if (r_n != N_LAST) begin
                        r_n <= r_n + 1'b1;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flatten the result bank onto the output vector.
    always_comb begin
        o_out_vec = '0;
        for (int n = 0; n < N_NEU; n++) begin
            o_out_vec[n*DW +: DW] = r_out[n];
        end
    end

    assign o_out_valid = r_out_valid;

endmodule
